alu_block_p: RTL and testbench
==============================

# alu_block_p

Parametrised successor to the 8-bit ALU block: a register file of NREGS general registers of WIDTH bits, a combinational ALU (add/sub with carry-in, and/or, xor/not, shift/half-swap), a 4-bit flags register and, optionally, a sequential shift-add multiplier with busy/done handshake. It sits on the CPU main bus as a bus-out/bus-in pair with an output-enable, which the top level merges onto the shared bus. Control lines are active-high and decoded internally.

## Interface

- WIDTH, 8, data width; even, 4..32
- NREGS, 4, general registers; power of two, 2..8
- RSW, $clog2(NREGS), derived register-select width; do not override

- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  reset; asynchronous, active-high
- bus_in  in  WIDTH  value on main bus
- bus_out  out  WIDTH  value driven to main bus
- bus_oe  out  1  bus_out valid; top level enables its bus driver
- out_en  in  1  drive selected source onto bus
- out_sel  in  4  0..NREGS-1 register; 8 flags; 9 ALU result; 10 product low; 11 product high
- load_en  in  1  load bus_in into selected destination
- load_sel  in  4  0..NREGS-1 register; 8 flags
- arg_l  in  RSW  left operand register
- arg_r  in  RSW  right operand register
- arg_r_zero  in  1  force right operand to zero
- op  in  3  ALU operation (see Operation)
- cin_use  in  1  ADD/SUB/SHL use stored C as carry-in
- calc  in  1  latch ALU flags at clock edge
- mul_start  in  1  start multiply (MUL builds only)
- mul_busy  out  1  multiplier running
- mul_done  out  1  one-cycle pulse, product valid
- flags  out  4  {N, Z, V, C}

## Operation

- Reset: all registers, flags, product = 0; mul_busy, mul_done = 0; bus_oe = 0 unless out_en asserted with a valid out_sel.
- bus_oe = out_en & (out_sel is a defined code); undefined codes: bus_oe = 0, bus_out = 0.
- L = reg[arg_l]; R = arg_r_zero ? 0 : reg[arg_r]; ci = cin_use ? C : default.
- op 0 ADD: L + R + ci (default 0). op 1 SUB: L + ~R + ci (default 1); C = carry out, i.e. 1 = no borrow.
- V for ADD/SUB: two's-complement signed overflow of the operation actually performed.
- op 2 AND, 3 OR, 4 XOR, 5 NOT (~L): C, V unchanged.
- op 6 SHL: {L[WIDTH-2:0], ci} (default 0); C = L[WIDTH-1]; V unchanged.
- op 7 SWAP: {L[WIDTH/2-1:0], L[WIDTH-1:WIDTH/2]}; C, V unchanged.
- N = result MSB, Z = result == 0, for all ops.
- calc: flags take new N/Z/V/C at edge. load_en with load_sel 8: flags = bus_in[3:0]; wins over calc in the same cycle.
- Load and read of same register in one cycle: readers see old value; new value visible next cycle.
- Multiplier: mul_start while idle latches L and R (unsigned), asserts mul_busy next cycle; WIDTH shift-add iterations; 2*WIDTH-bit product written to product regs and mul_done pulsed on the final iteration's edge. mul_start while busy is ignored. On mul_done, Z = (product == 0), C = (product high != 0), N, V unchanged; a simultaneous calc or flags load takes priority.
- rst mid-multiply aborts: busy cleared, product zeroed, no done pulse.

## Timing

- Bus output and ALU result combinational from registered state and select inputs; zero-cycle latency.
- Register/flags loads: one edge.
- Multiply: start at edge k -> mul_busy high k+1..k+WIDTH; mul_done high one cycle after edge k+WIDTH; product readable from that cycle; new start accepted in the mul_done cycle.

## Configuration

- ALU_MUL_EN defined: multiplier, product registers, out_sel 10/11 present.
- Undefined: mul_busy, mul_done tied 0; mul_start ignored; out_sel 10/11 treated as undefined (bus_oe = 0).

## Structure

- Package alu_pkg: op codes, out_sel/load_sel codes, flag bit indices {N=3, Z=2, V=1, C=0}.
- Sub-module alu_mul_seq: iteration counter, shift-add datapath, busy/done; instantiated only under ALU_MUL_EN.

## Test plan

- WIDTH=8: load A=0x7F, B=0x01, op ADD, calc -> result 0x80, flags N=1 Z=0 V=1 C=0.
- A=0x00, B=0x01, op SUB, calc -> 0xFF, C=0 (borrow), N=1; repeat with cin_use, C=0 -> 0xFE.
- A=0x81, op SHL cin_use C=1 -> 0x03, C=1; op SWAP on 0xA5 -> 0x5A, C unchanged.
- Same-cycle out_sel=A, load_sel=B with bus_in=bus_out -> B equals A next cycle; undefined out_sel 12 -> bus_oe=0.
- ALU_MUL_EN, WIDTH=8: 0xFF*0xFF -> mul_done exactly 8 cycles after busy, product 0xFE01, C=1, Z=0; second start while busy ignored.
- rst asserted mid-multiply (cycle 4) -> busy 0 immediately, no done, product 0, all registers and flags 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the parametrised ALU block: op codes, bus select codes
// and flag bit positions.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_NOT  = 3'd5,
    OP_SHL  = 3'd6,
    OP_SWAP = 3'd7
  } alu_op_e;

  // Select codes 0..NREGS-1 address the general registers directly.
  localparam logic [3:0] SEL_FLAGS   = 4'd8;
  localparam logic [3:0] SEL_RESULT  = 4'd9;
  localparam logic [3:0] SEL_PROD_LO = 4'd10;
  localparam logic [3:0] SEL_PROD_HI = 4'd11;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

endpackage

// File: rtl/alu_block_mul.sv
// Sequential unsigned shift-add multiplier: one partial product per clock,
// WIDTH iterations, one-cycle done pulse when the product register is written.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH);

  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;

  always_comb begin
    busy_d   = busy_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    prod_d   = prod_q;
    mplier_d = mplier_q;
    if (busy_q) begin
      acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == CW'(WIDTH - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        prod_d = acc_d;
      end
    end else if (start) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
    end else begin
      busy_q   <= busy_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      prod_q   <= prod_d;
      mplier_q <= mplier_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = prod_q;

endmodule

// File: rtl/alu_block_p.sv
// Register file + combinational ALU + flags with a bus-out/bus-in pair.
// Define ALU_MUL_EN to include the sequential multiplier and product registers.
module alu_block_p
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  parameter int RSW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] bus_in,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_oe,
  input  logic             out_en,
  input  logic [3:0]       out_sel,
  input  logic             load_en,
  input  logic [3:0]       load_sel,
  input  logic [RSW-1:0]   arg_l,
  input  logic [RSW-1:0]   arg_r,
  input  logic             arg_r_zero,
  input  logic [2:0]       op,
  input  logic             cin_use,
  input  logic             calc,
  input  logic             mul_start,
  output logic             mul_busy,
  output logic             mul_done,
  output logic [3:0]       flags
);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [3:0]       flags_q, flags_d;

  logic [WIDTH-1:0] opl, opr, addend, res;
  logic [WIDTH:0]   sum;
  logic             ci, res_c, res_v;

  // SUB is L + ~R + ci, so both arithmetic ops share one adder.
  always_comb begin
    opl    = regs_q[arg_l];
    opr    = arg_r_zero ? '0 : regs_q[arg_r];
    addend = (alu_op_e'(op) == OP_SUB) ? ~opr : opr;
    ci     = cin_use ? flags_q[FLAG_C] : (alu_op_e'(op) == OP_SUB);
    sum    = {1'b0, opl} + {1'b0, addend} + {{WIDTH{1'b0}}, ci};
    res    = '0;
    res_c  = flags_q[FLAG_C];
    res_v  = flags_q[FLAG_V];
    case (alu_op_e'(op))
      OP_ADD, OP_SUB: begin
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (opl[WIDTH-1] == addend[WIDTH-1]) && (res[WIDTH-1] != opl[WIDTH-1]);
      end
      OP_AND:  res = opl & opr;
      OP_OR:   res = opl | opr;
      OP_XOR:  res = opl ^ opr;
      OP_NOT:  res = ~opl;
      OP_SHL: begin
        res   = {opl[WIDTH-2:0], ci};
        res_c = opl[WIDTH-1];
      end
      OP_SWAP: res = {opl[WIDTH/2-1:0], opl[WIDTH-1:WIDTH/2]};
      default: res = '0;
    endcase
  end

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] prod;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (opl),
    .b       (opr),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (prod)
  );
`else
  logic unused_mul_start;
  assign unused_mul_start = mul_start;
  assign mul_busy = 1'b0;
  assign mul_done = 1'b0;
`endif

  always_comb begin
    bus_out = '0;
    bus_oe  = 1'b0;
    if (out_en) begin
      if (out_sel < 4'(NREGS)) begin
        bus_oe  = 1'b1;
        bus_out = regs_q[out_sel[RSW-1:0]];
      end else begin
        case (out_sel)
          SEL_FLAGS: begin
            bus_oe  = 1'b1;
            bus_out = WIDTH'(flags_q);
          end
          SEL_RESULT: begin
            bus_oe  = 1'b1;
            bus_out = res;
          end
`ifdef ALU_MUL_EN
          SEL_PROD_LO: begin
            bus_oe  = 1'b1;
            bus_out = prod[WIDTH-1:0];
          end
          SEL_PROD_HI: begin
            bus_oe  = 1'b1;
            bus_out = prod[2*WIDTH-1:WIDTH];
          end
`endif
          default: begin
            bus_oe  = 1'b0;
            bus_out = '0;
          end
        endcase
      end
    end
  end

  // Later assignments win: bus load of flags over calc over multiply completion.
  always_comb begin
    flags_d = flags_q;
`ifdef ALU_MUL_EN
    if (mul_done) begin
      flags_d[FLAG_Z] = (prod == '0);
      flags_d[FLAG_C] = |prod[2*WIDTH-1:WIDTH];
    end
`endif
    if (calc)
      flags_d = {res[WIDTH-1], (res == '0), res_v, res_c};
    if (load_en && (load_sel == SEL_FLAGS))
      flags_d = bus_in[3:0];
  end

  always_comb begin
    for (int i = 0; i < NREGS; i++)
      regs_d[i] = regs_q[i];
    if (load_en && (load_sel < 4'(NREGS)))
      regs_d[load_sel[RSW-1:0]] = bus_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
      for (int i = 0; i < NREGS; i++)
        regs_q[i] <= '0;
    end else begin
      flags_q <= flags_d;
      for (int i = 0; i < NREGS; i++)
        regs_q[i] <= regs_d[i];
    end
  end

  assign flags = flags_q;

endmodule

// File: tb/tb_alu_block_p.sv
// Self-checking bench for alu_block_p: directed cases with literal expectations,
// then randomized traffic checked every cycle against an arithmetic model.
module tb_alu_block_p;
  import alu_pkg::*;

  localparam int W  = 8;
  localparam int NR = 4;
  localparam int RS = 2;
  localparam longint FULL = longint'(1) << W;
  localparam longint MASK = FULL - 1;
  localparam longint HALF = longint'(1) << (W - 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  bus_in, bus_out;
  logic          bus_oe, out_en, load_en, arg_r_zero, cin_use, calc, mul_start;
  logic [3:0]    out_sel, load_sel, flags;
  logic [RS-1:0] arg_l, arg_r;
  logic [2:0]    op;
  logic          mul_busy, mul_done;

  always #5 clk = ~clk;

  alu_block_p #(.WIDTH(W), .NREGS(NR)) dut (
    .clk(clk), .rst(rst), .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
    .out_en(out_en), .out_sel(out_sel), .load_en(load_en), .load_sel(load_sel),
    .arg_l(arg_l), .arg_r(arg_r), .arg_r_zero(arg_r_zero), .op(op),
    .cin_use(cin_use), .calc(calc), .mul_start(mul_start),
    .mul_busy(mul_busy), .mul_done(mul_done), .flags(flags)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference state
  longint m_regs [NR];
  logic [3:0] m_flags;
  longint m_prod, m_pend;
  int     m_cnt;
  bit     m_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint sgn(input longint v);
    return (v >= HALF) ? v - FULL : v;
  endfunction

  function automatic void model_alu(output longint res, output logic [3:0] nf);
    longint l, r, tot, s;
    longint ci;
    l   = m_regs[arg_l];
    r   = arg_r_zero ? 0 : m_regs[arg_r];
    nf  = m_flags;
    res = 0;
    case (op)
      3'd0: begin
        ci = cin_use ? longint'(m_flags[0]) : 0;
        tot = l + r + ci;
        s = sgn(l) + sgn(r) + ci;
        res = tot & MASK;
        nf[0] = (tot >= FULL);
        nf[1] = (s >= HALF) || (s < -HALF);
      end
      3'd1: begin
        ci = cin_use ? longint'(m_flags[0]) : 1;
        tot = l + (MASK - r) + ci;
        s = sgn(l) - sgn(r) - 1 + ci;
        res = tot & MASK;
        nf[0] = (tot >= FULL);
        nf[1] = (s >= HALF) || (s < -HALF);
      end
      3'd2: res = l & r;
      3'd3: res = l | r;
      3'd4: res = l ^ r;
      3'd5: res = MASK - l;
      3'd6: begin
        ci = cin_use ? longint'(m_flags[0]) : 0;
        tot = 2 * l + ci;
        res = tot & MASK;
        nf[0] = (tot >= FULL);
      end
      default: res = ((l % (longint'(1) << (W/2))) << (W/2)) | (l >> (W/2));
    endcase
    nf[3] = (res >= HALF);
    nf[2] = (res == 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = 0;
    m_flags = 4'h0;
    m_prod  = 0;
    m_pend  = 0;
    m_cnt   = 0;
    m_done  = 1'b0;
  endtask

  task automatic model_step();
    longint res;
    logic [3:0] nf, f;
    bit old_done;
    if (rst) begin
      model_reset();
      return;
    end
    model_alu(res, nf);
    f = m_flags;
    old_done = m_done;
    m_done = 1'b0;
`ifdef ALU_MUL_EN
    if (old_done) begin
      f[2] = (m_prod == 0);
      f[0] = ((m_prod >> W) != 0);
    end
    if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_prod = m_pend;
        m_done = 1'b1;
      end
    end else if (mul_start) begin
      m_pend = m_regs[arg_l] * (arg_r_zero ? 0 : m_regs[arg_r]);
      m_cnt  = W;
    end
`endif
    if (calc) f = nf;
    if (load_en && load_sel == 4'd8) f = bus_in[3:0];
    if (load_en && load_sel < 4'(NR)) m_regs[load_sel[RS-1:0]] = longint'(bus_in);
    m_flags = f;
  endtask

  task automatic check_outputs();
    longint res, eb;
    logic [3:0] nf;
    bit eo;
    model_alu(res, nf);
    eo = 1'b0;
    eb = 0;
    if (out_en) begin
      if (out_sel < 4'(NR)) begin
        eo = 1'b1; eb = m_regs[out_sel[RS-1:0]];
      end else if (out_sel == 4'd8) begin
        eo = 1'b1; eb = longint'(m_flags);
      end else if (out_sel == 4'd9) begin
        eo = 1'b1; eb = res;
      end
`ifdef ALU_MUL_EN
      else if (out_sel == 4'd10) begin
        eo = 1'b1; eb = m_prod & MASK;
      end else if (out_sel == 4'd11) begin
        eo = 1'b1; eb = m_prod >> W;
      end
`endif
    end
    check("bus_oe", bus_oe, eo);
    check("bus_out", bus_out, eb);
    check("flags", flags, m_flags);
    check("mul_busy", mul_busy, m_cnt > 0);
    check("mul_done", mul_done, m_done);
  endtask

  // Inputs are set at the falling edge; outputs compared 1 ns later.
  task automatic tick();
    #1 check_outputs();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    out_en = 0; out_sel = 0; load_en = 0; load_sel = 0; bus_in = 0;
    arg_l = 0; arg_r = 0; arg_r_zero = 0; op = 0; cin_use = 0; calc = 0; mul_start = 0;
  endtask

  task automatic load(input logic [3:0] sel, input logic [W-1:0] val);
    idle();
    load_en = 1; load_sel = sel; bus_in = val;
    tick();
  endtask

  int busy_n;
  bit done_seen;

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1 check("rst_flags", flags, 4'h0);
    check("rst_busy", mul_busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // ADD overflow: 0x7F + 0x01
    load(4'd0, 8'h7F);
    load(4'd1, 8'h01);
    idle(); op = 3'd0; arg_l = 0; arg_r = 1; calc = 1; out_en = 1; out_sel = 4'd9;
    #1 check("add_res", bus_out, 8'h80);
    tick();
    idle();
    #1 check("add_flags", flags, 4'b1010);
    tick();

    // SUB with borrow, then chained with C as carry-in
    load(4'd0, 8'h00);
    load(4'd1, 8'h01);
    idle(); op = 3'd1; arg_l = 0; arg_r = 1; calc = 1; out_en = 1; out_sel = 4'd9;
    #1 check("sub_res", bus_out, 8'hFF);
    tick();
    idle(); op = 3'd1; arg_l = 0; arg_r = 1; cin_use = 1; out_en = 1; out_sel = 4'd9;
    #1 check("sub_flags", flags, 4'b1000);
    check("sbc_res", bus_out, 8'hFE);
    tick();

    // SHL with carry-in, SWAP leaves C alone
    load(4'd0, 8'h81);
    load(4'd8, 8'h01);
    idle(); op = 3'd6; arg_l = 0; cin_use = 1; calc = 1; out_en = 1; out_sel = 4'd9;
    #1 check("shl_res", bus_out, 8'h03);
    tick();
    load(4'd2, 8'hA5);
    idle(); op = 3'd7; arg_l = 2; calc = 1; out_en = 1; out_sel = 4'd9;
    #1 check("shl_flags", flags, 4'b0001);
    check("swap_res", bus_out, 8'h5A);
    tick();
    idle();
    #1 check("swap_flags", flags, 4'b0001);
    tick();

    // Register-to-register move through the bus in one cycle
    load(4'd3, 8'h3C);
    idle(); out_en = 1; out_sel = 4'd3; load_en = 1; load_sel = 4'd1; bus_in = 8'h3C;
    #1 check("move_src", bus_out, 8'h3C);
    tick();
    idle(); out_en = 1; out_sel = 4'd1;
    #1 check("move_dst", bus_out, 8'h3C);
    tick();

    // Undefined selects
    idle(); out_en = 1; out_sel = 4'd12;
    #1 check("undef_oe", bus_oe, 1'b0);
    check("undef_bus", bus_out, 0);
    tick();
`ifndef ALU_MUL_EN
    idle(); out_en = 1; out_sel = 4'd10; mul_start = 1;
    #1 check("nomul_oe", bus_oe, 1'b0);
    tick();
    idle();
    #1 check("nomul_busy", mul_busy, 1'b0);
    tick();
`else
    // 0xFF * 0xFF, with an ignored second start while busy
    load(4'd0, 8'hFF);
    load(4'd1, 8'hFF);
    idle(); arg_l = 0; arg_r = 1; mul_start = 1;
    tick();
    busy_n = 0;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      idle(); arg_l = 0; arg_r = 1;
      mul_start = (i == 2); arg_r_zero = (i == 2);
      #1;
      if (mul_done) begin
        done_seen = 1;
        break;
      end
      if (mul_busy) busy_n++;
      tick();
    end
    check("mul_done_seen", done_seen, 1'b1);
    check("mul_busy_len", busy_n, W);
    idle(); out_en = 1; out_sel = 4'd10;
    #1 check("mul_prod_lo", bus_out, 8'h01);
    out_sel = 4'd11;
    #1 check("mul_prod_hi", bus_out, 8'hFE);
    tick();
    idle();
    #1 check("mul_flag_c", flags[0], 1'b1);
    check("mul_flag_z", flags[2], 1'b0);
    tick();

    // Reset four cycles into a multiply
    idle(); arg_l = 0; arg_r = 1; mul_start = 1;
    tick();
    idle();
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    model_reset();
    out_en = 1; out_sel = 4'd0;
    #1 check("abort_busy", mul_busy, 1'b0);
    check("abort_flags", flags, 4'h0);
    check("abort_reg0", bus_out, 0);
    tick();
    rst = 1'b0;
    idle(); out_en = 1; out_sel = 4'd10;
    for (int i = 0; i < 12; i++) tick();
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int ls;
      out_en     = ($urandom_range(0, 3) != 0);
      out_sel    = 4'($urandom_range(0, 15));
      load_en    = ($urandom_range(0, 9) < 3);
      ls         = $urandom_range(0, 9);
      load_sel   = (ls < NR) ? 4'(ls) : ((ls < 8) ? 4'd8 : 4'($urandom_range(4, 15)));
      bus_in     = W'($urandom);
      arg_l      = RS'($urandom);
      arg_r      = RS'($urandom);
      arg_r_zero = ($urandom_range(0, 7) == 0);
      op         = 3'($urandom);
      cin_use    = 1'($urandom);
      calc       = ($urandom_range(0, 2) == 0);
      mul_start  = ($urandom_range(0, 5) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
